// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM states, RAM depth default.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned MEM_WORDS_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: load extract/extend and sub-word store merge.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] mask;

  always_comb begin
    shamt     = {offset, 3'b000};
    shifted   = data >> shamt;
    mask      = '0;
    load_data = data;
    merged    = wdata;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{sgn & shifted[7]}}, shifted[7:0]};
        mask      = 32'h0000_00FF << shamt;
        merged    = (data & ~mask) | ((wdata << shamt) & mask);
      end
      SZ_HALF: begin
        load_data = {{16{sgn & shifted[15]}}, shifted[15:0]};
        mask      = 32'h0000_FFFF << shamt;
        merged    = (data & ~mask) | ((wdata << shamt) & mask);
      end
      default: begin
        load_data = data;
        merged    = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store controller for a word-only single-port RAM, with alignment/range
// checking and read-modify-write for byte and halfword stores.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = MEM_WORDS_DEF,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_done,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [31:0]           ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_write,
  output logic                  ram_write_en,
  output logic                  ram_read_en,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

  state_t      state_q, state_d;
  logic        wr_q, sgn_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, word_q, rdata_q;
  logic        acc_err;
  logic [31:0] align_in, load_data, merged;

  always_comb begin
    acc_err = 1'b0;
    if (req_size == 2'b11)                                acc_err = 1'b1;
    if (req_size == SZ_HALF && req_addr[0])               acc_err = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)    acc_err = 1'b1;
    if (req_addr >= ADDR_LIMIT)                           acc_err = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (acc_err)                              state_d = RESP;
          else if (req_write && req_size == SZ_WORD) state_d = WRITE;
          else                                       state_d = READ;
        end
      end
      READ:    state_d = wr_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // In READ the live RAM word feeds extraction; afterwards the captured copy feeds the merge.
  assign align_in = (state_q == READ) ? ram_data_out : word_q;

  mem_lane_align u_align (
    .data      (align_in),
    .offset    (addr_q[1:0]),
    .size      (size_q),
    .sgn       (sgn_q),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        wr_q    <= req_write;
        size_q  <= req_size;
        sgn_q   <= req_signed;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= acc_err;
      end
      if (state_q == READ) begin
        word_q <= ram_data_out;
        if (!wr_q) rdata_q <= load_data;
      end
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign ram_read_en    = (state_q == READ);
  assign ram_write_en   = (state_q == WRITE);
  assign resp_done      = (state_q == RESP);
  assign resp_err       = (state_q == RESP) & err_q;
  assign resp_rdata     = rdata_q;
  assign ram_address    = {addr_q[31:2], 2'b00};
  assign ram_data_write = merged;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: directed test-plan cases plus randomized traffic against a behavioural model.
module tb_mem_access_unit;

  localparam int unsigned MW = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_done, resp_err, ram_write_en, ram_read_en;
  logic [31:0] resp_rdata, ram_address, ram_data_write, ram_data_out;

  mem_access_unit #(.MEM_WORDS(MW), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_done(resp_done), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .ram_address(ram_address), .ram_data_write(ram_data_write),
    .ram_write_en(ram_write_en), .ram_read_en(ram_read_en), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // Attached RAM (driven by DUT strobes) and the model's own view of memory.
  logic [31:0] ram     [MW];
  logic [31:0] ref_mem [MW];
  assign ram_data_out = ram_read_en ? ram[ram_address[6:2]] : 32'hDEAD_BEEF;
  always @(posedge clk) if (ram_write_en) ram[ram_address[6:2]] <= ram_data_write;

  int checks = 0;
  int errs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: each accepted request is turned into a cycle schedule
  // (read strobe cycle, write strobe cycle, response cycle) counted from the accept edge.
  bit          busy = 1'b0;
  int          t, lat, rd_cyc, wr_cyc, widx;
  logic        exp_err, is_load, is_store;
  logic [31:0] exp_addr, exp_wword, exp_rdata = '0, new_load;

  task automatic predict();
    logic [31:0] a, w, v, mask;
    int sh;
    a  = req_addr;
    sh = 8 * int'(a[1:0]);
    exp_err = (req_size == 2'b11) || (req_size == 2'b01 && a[0]) ||
              (req_size == 2'b10 && a[1:0] != 2'b00) || (a >= MW * 4);
    widx     = int'(a[6:2]);
    w        = ref_mem[widx];
    exp_addr = a & 32'hFFFF_FFFC;
    is_load  = 1'b0;
    is_store = 1'b0;
    rd_cyc   = 0;
    wr_cyc   = 0;
    if (exp_err) begin
      lat = 1;
    end else if (!req_write) begin
      is_load = 1'b1; lat = 2; rd_cyc = 1;
      if (req_size == 2'b00) begin
        v = (w >> sh) & 32'hFF;
        if (req_signed && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (req_size == 2'b01) begin
        v = (w >> sh) & 32'hFFFF;
        if (req_signed && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else v = w;
      new_load = v;
    end else if (req_size == 2'b10) begin
      is_store = 1'b1; lat = 2; wr_cyc = 1; exp_wword = req_wdata;
    end else begin
      is_store = 1'b1; lat = 3; rd_cyc = 1; wr_cyc = 2;
      mask = ((req_size == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
      exp_wword = (w & ~mask) | ((req_wdata << sh) & mask);
    end
    t    = 0;
    busy = 1'b1;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      busy      = 1'b0;
      exp_rdata = '0;
    end else if (busy) begin
      t++;
      if (t == lat && is_load) exp_rdata = new_load;
      chk("ready_busy", req_ready, 0);
      chk("read_en", ram_read_en, t == rd_cyc);
      chk("write_en", ram_write_en, t == wr_cyc);
      if (t == rd_cyc || t == wr_cyc) chk("ram_address", ram_address, exp_addr);
      if (t == wr_cyc) chk("ram_data_write", ram_data_write, exp_wword);
      chk("resp_done", resp_done, t == lat);
      chk("resp_err", resp_err, (t == lat) && exp_err);
      chk("resp_rdata", resp_rdata, exp_rdata);
      if (t == lat) begin
        if (is_store) ref_mem[widx] = exp_wword;
        busy = 1'b0;
      end
    end else begin
      chk("ready_idle", req_ready, 1);
      chk("strobes_idle", {30'd0, ram_read_en, ram_write_en}, 0);
      chk("done_idle", {30'd0, resp_done, resp_err}, 0);
      chk("rdata_idle", resp_rdata, exp_rdata);
      if (req_valid) predict();
    end
  end

  // Issue one request and observe it up to its response.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int n_lat, output int rdc, output int wrc,
                        output logic err, output logic [31:0] rdata,
                        output logic [31:0] wword, output logic [31:0] waddr);
    bit acc;
    n_lat = -1; rdc = 0; wrc = 0; err = 1'bx; rdata = 'x; wword = 'x; waddr = 'x;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++) begin
      @(negedge clk);
      acc = req_ready;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!acc) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      rdc += int'(ram_read_en);
      wrc += int'(ram_write_en);
      if (ram_write_en) begin wword = ram_data_write; waddr = ram_address; end
      if (resp_done) begin
        n_lat = n; err = resp_err; rdata = resp_rdata;
        return;
      end
    end
    chk("resp_timeout", 0, 1);
  endtask

  task automatic run(input string nm, input logic wr, input logic [1:0] sz, input logic sg,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input int e_lat, input int e_rd, input int e_wr, input logic e_err,
                     input bit chk_rd, input logic [31:0] e_rdata);
    int n_lat, rdc, wrc;
    logic err;
    logic [31:0] rdata, wword, waddr;
    do_req(wr, sz, sg, addr, wd, n_lat, rdc, wrc, err, rdata, wword, waddr);
    chk({nm, "_latency"}, n_lat, e_lat);
    chk({nm, "_rd_cycles"}, rdc, e_rd);
    chk({nm, "_wr_cycles"}, wrc, e_wr);
    chk({nm, "_err"}, err, e_err);
    if (chk_rd) chk({nm, "_rdata"}, rdata, e_rdata);
  endtask

  initial begin
    int   n_lat, rdc, wrc, ndone;
    logic err;
    logic [31:0] rdata, wword, waddr;

    for (int i = 0; i < MW; i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[1]     = '0;
    ref_mem[1] = '0;

    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_done", resp_done, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_strobes", {30'd0, ram_read_en, ram_write_en}, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_address", ram_address, 0);
    chk("rst_wdata", ram_data_write, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    do_req(1'b1, 2'b10, 1'b0, 32'h08, 32'h80FF_1234, n_lat, rdc, wrc, err, rdata, wword, waddr);
    chk("sw_latency", n_lat, 2);
    chk("sw_wr_cycles", wrc, 1);
    chk("sw_rd_cycles", rdc, 0);
    chk("sw_address", waddr, 32'h08);
    chk("sw_err", err, 0);

    run("lb_09",  1'b0, 2'b00, 1'b1, 32'h09, '0, 2, 1, 0, 1'b0, 1'b1, 32'h0000_0012);
    run("lb_0b",  1'b0, 2'b00, 1'b1, 32'h0B, '0, 2, 1, 0, 1'b0, 1'b1, 32'hFFFF_FF80);
    run("lbu_0b", 1'b0, 2'b00, 1'b0, 32'h0B, '0, 2, 1, 0, 1'b0, 1'b1, 32'h0000_0080);
    run("lhu_0a", 1'b0, 2'b01, 1'b0, 32'h0A, '0, 2, 1, 0, 1'b0, 1'b1, 32'h0000_80FF);
    run("lh_0a",  1'b0, 2'b01, 1'b1, 32'h0A, '0, 2, 1, 0, 1'b0, 1'b1, 32'hFFFF_80FF);

    do_req(1'b1, 2'b00, 1'b0, 32'h0A, 32'h0000_00AB, n_lat, rdc, wrc, err, rdata, wword, waddr);
    chk("sb_latency", n_lat, 3);
    chk("sb_rd_cycles", rdc, 1);
    chk("sb_wr_cycles", wrc, 1);
    chk("sb_merged", wword, 32'h80AB_1234);
    run("lw_08", 1'b0, 2'b10, 1'b0, 32'h08, '0, 2, 1, 0, 1'b0, 1'b1, 32'h80AB_1234);

    run("err_lw06",  1'b0, 2'b10, 1'b0, 32'h06, '0, 1, 0, 0, 1'b1, 1'b1, 32'h80AB_1234);
    run("err_lh03",  1'b0, 2'b01, 1'b1, 32'h03, '0, 1, 0, 0, 1'b1, 1'b0, '0);
    run("err_sw80",  1'b1, 2'b10, 1'b0, 32'h80, 32'h1, 1, 0, 0, 1'b1, 1'b0, '0);
    run("err_size3", 1'b0, 2'b11, 1'b0, 32'h00, '0, 1, 0, 0, 1'b1, 1'b0, '0);

    // Abort a sub-word store while its write strobe is up.
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_signed = 1'b0;
    req_addr = 32'h04; req_wdata = 32'h0000_5555;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_read_phase", ram_read_en, 1);
    @(negedge clk);
    chk("abort_write_phase", ram_write_en, 1);
    #2 reset = 1'b1;
    #1;
    chk("abort_write_drop", ram_write_en, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_read_drop", ram_read_en, 0);
    @(negedge clk); #2 reset = 1'b0;
    ndone = 0;
    repeat (4) begin
      @(negedge clk);
      ndone += int'(resp_done);
    end
    chk("abort_no_done", ndone, 0);
    run("lw_04", 1'b0, 2'b10, 1'b0, 32'h04, '0, 2, 1, 0, 1'b0, 1'b1, 32'h0000_0000);

    // Random traffic; req_valid often stays high while busy with changing contents.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      req_valid  = ($urandom_range(0, 3) != 0);
      req_write  = 1'($urandom_range(0, 1));
      req_size   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      req_signed = 1'($urandom_range(0, 1));
      req_addr   = ($urandom_range(0, 15) == 0) ? 32'($urandom) : 32'($urandom_range(0, 127));
      req_wdata  = $urandom;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("drained", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side load/store controller between the MIPS datapath and the single-port data RAM.
- Accepts one word, halfword or byte load/store request at a time and drives the RAM address, write data, write enable and read enable.
- Returns sign- or zero-extended load data to the core.
- Checks alignment and range, and performs read-modify-write for sub-word stores, since the RAM writes whole words only.

Parameters:
- MEM_WORDS, 32, number of 32-bit words in the attached RAM; byte addresses at or above MEM_WORDS*4 are out of range.
- DATA_WIDTH, 32, data width; fixed at 32 for byte-lane logic.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-high reset
- req_valid  input  1  request strobe, sampled only when req_ready=1
- req_ready  output  1  high in IDLE only
- req_write  input  1  1=store, 0=load
- req_size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  input  1  loads only: 1 sign-extend, 0 zero-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- resp_done  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load data; holds until the next accept
- resp_err  output  1  valid with resp_done: misaligned, out of range, or illegal size
- ram_address  output  32  word-aligned byte address {addr[31:2],2'b00}
- ram_data_write  output  32  merged write word
- ram_write_en  output  1  RAM write strobe
- ram_read_en  output  1  RAM read strobe
- ram_data_out  input  32  combinational RAM read data; only valid while ram_read_en=1

Behaviour:
- Reset values:
  - State is IDLE, with req_ready=1.
  - resp_done, resp_err, ram_write_en and ram_read_en are 0.
  - resp_rdata, ram_address and ram_data_write are 0.
  - The request and merge registers are cleared.
- Accept: on a rising edge with IDLE and req_valid=1, latch write, size, signed, addr and wdata.
- Error check at accept: an error is raised for any of the following.
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
  - addr>=MEM_WORDS*4.
  - size=11.
- On error the next state is RESP with resp_err=1; no RAM strobe is ever asserted for that request.
- States and transitions:
  - IDLE -> READ for a load or a sub-word store.
  - IDLE -> WRITE for a word store.
  - IDLE -> RESP on error.
  - READ: ram_read_en=1. At the end of the cycle, capture ram_data_out. A load then goes to RESP; a sub-word store goes to WRITE.
  - WRITE: ram_write_en=1 with ram_data_write = merged word; the RAM commits at the end of the cycle. Next state is RESP.
  - RESP: resp_done=1 for exactly one cycle. Next state is IDLE.
- RAM strobes are decoded combinationally from state. ram_write_en and ram_read_en are never both high.
- Latency from the accepting edge to resp_done:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- Lanes are little-endian.
  - Byte offset k occupies bits [8k+7:8k].
  - A halfword at offset 2 occupies bits [31:16].
- Load extraction: shift the selected lane to bit 0, then sign- or zero-extend per req_signed. A word load ignores req_signed.
- Store merge: replace only the addressed lane of the captured word with req_wdata[7:0] or [15:0]; other lanes keep their read value.
- req_valid is ignored outside IDLE; there is no queuing.
- resp_rdata updates only in RESP for a successful load. It is unchanged for stores and errors.
- Reset asserted in any state:
  - Immediate return to IDLE.
  - Strobes drop without waiting for a clock edge.
  - No resp_done is produced for the aborted request.

Decomposition:
- Shared package mem_pkg holds:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - The state enum IDLE, READ, WRITE, RESP.
  - The MEM_WORDS default.
- One combinational sub-module, mem_lane_align, computes the load extract/extend and the store merge from the word, offset, size, signed flag and wdata.

Test Plan:
- After reset, SW addr 0x08 data 0x80FF1234:
  - ram_write_en is high for exactly 1 cycle, with ram_address=0x08.
  - resp_done occurs 2 cycles after accept, with resp_err=0.
- LB signed 0x09 -> resp_rdata=0x00000012. LB signed 0x0B -> 0xFFFFFF80. LBU 0x0B -> 0x00000080. LHU 0x0A -> 0x000080FF. LH 0x0A -> 0xFFFF80FF.
- SB 0x0A data 0x000000AB:
  - One cycle of ram_read_en, then one cycle of ram_write_en with ram_data_write=0x80AB1234.
  - resp_done occurs 3 cycles after accept.
  - A following LW 0x08 returns 0x80AB1234.
- Misaligned LW 0x06, LH 0x03, SW to 0x80 (MEM_WORDS=32), and size=11:
  - Each gives resp_err=1 one cycle after accept.
  - ram_read_en and ram_write_en stay 0 throughout.
- Assert reset mid-WRITE of SH 0x04:
  - ram_write_en falls in the same cycle and req_ready=1.
  - No resp_done appears.
  - A following LW 0x04 completes normally.
- Hold req_valid high while busy with different addresses: only the request present in IDLE is accepted, and back-to-back accepts are spaced at the stated latencies.
